bitserial_logic_seq: RTL
========================

// Module: bitserial_logic_seq
// PURPOSE
//  Bit-serial sequencer for the 1-bit logic unit (opcode decoder + AND/OR/XOR/NOT stage).
//  Accepts a WIDTH-bit operand pair and 2-bit opcode via valid/ready.
//  Drives the unit's opcode pins and one operand bit per cycle, LSB first.
//  Collects the unit's 1-bit result into a WIDTH-bit word returned via valid/ready.
// PARAMETERS
//  WIDTH    8   operand/result width in bits, >= 2
//  CNT_W    $clog2(WIDTH)   bit-counter width, derived, not overridden
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  start_valid  in   1      request present
//  start_ready  out  1      sequencer can accept a request
//  op           in   2      00 AND, 01 OR, 10 XOR, 11 NOT (NOT of opa)
//  opa          in   WIDTH  operand A -> unit i0
//  opb          in   WIDTH  operand B -> unit i1 (ignored for NOT)
//  alu_a        out  1      unit opcode select A = latched op[1]
//  alu_b        out  1      unit opcode select B = latched op[0]
//  alu_i0       out  1      current bit of opa
//  alu_i1       out  1      current bit of opb
//  alu_oput     in   1      unit result, combinational from alu_* outputs
//  res_valid    out  1      result word available
//  res_ready    in   1      consumer takes result
//  result       out  WIDTH  assembled result word
//  busy         out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - state=IDLE, cnt=0, op_q=0, opa_q=opb_q=0, result=0
//   - res_valid=0, busy=0, start_ready=1 the following cycle
//   - applies from any state; in-flight operation is discarded
//  IDLE:
//   - start_ready=1, alu_i0=alu_i1=0
//   - start_valid=1: latch op/opa/opb, clear result and cnt, -> RUN
//  RUN:
//   - start_ready=0
//   - alu_i0=opa_q[cnt], alu_i1=opb_q[cnt]
//   - each edge: result[cnt]<=alu_oput, cnt<=cnt+1
//   - cnt==WIDTH-1 at edge: cnt<=0, -> DONE
//  DONE:
//   - res_valid=1; result, op_q and alu_* held stable
//   - res_ready=1 -> IDLE; new request accepted no earlier than the next cycle
//   - res_ready=0 -> stay in DONE indefinitely
//  Timing and ordering:
//   - latency: accept edge + WIDTH RUN cycles; res_valid rises on cycle WIDTH+1
//   - throughput: one request per WIDTH+2 cycles
//   - alu_a/alu_b follow op_q in every state; no combinational path from start_* to alu_*
//   - start_valid outside IDLE is ignored; caller holds request until start_ready
// CONFIGURATION
//  BSLS_SELFCHECK_EN
//   - defined: extra output port chk_err (1 bit)
//   - in DONE, chk_err=1 iff result != parallel op_q applied to opa_q/opb_q
//   - chk_err=0 in all other states and on reset
//  Not defined: port and compare logic absent; all other behaviour identical.
// TESTING (WIDTH=8, opa=0xA5, opb=0x3C unless noted)
//  - op=00 AND -> result=0x24; res_valid high exactly 9 cycles after accept edge
//  - op=01 OR -> 0xBD; op=10 XOR -> 0x99; op=11 NOT -> 0x5A
//    (NOT repeated with opb=0xFF: still 0x5A)
//  - res_ready low 5 cycles in DONE: result/res_valid stable, start_ready=0,
//    start_valid pulses ignored; release -> IDLE next cycle
//  - rst_n low at RUN cnt=3 -> next cycle state IDLE, result=0, res_valid=0,
//    start_ready=1; fresh AND request then completes with 0x24
//  - bit-order probe: opa=0x01, opb=0x00, op=OR -> alu_i0=1 only in first RUN cycle;
//    result=0x01
//  - BSLS_SELFCHECK_EN: alu_oput forced 0 during OR -> result=0x00, chk_err=1 in DONE;
//    unforced -> chk_err=0

Source files
------------

// File: rtl/bitserial_logic_seq.sv
// Bit-serial sequencer feeding a 1-bit logic unit LSB first and reassembling its result word.
// Optional BSLS_SELFCHECK_EN adds chk_err, comparing the serial result against a parallel reference.
module bitserial_logic_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_i0,
    output logic             alu_i1,
    input  logic             alu_oput,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
`ifdef BSLS_SELFCHECK_EN
    output logic             chk_err,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until then, ready never depends on valid.

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic               start_ready_q;
    logic               res_valid_q;
    logic               busy_q;
    logic               last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign cnt_d    = cnt_q + 1'b1;

    always_comb begin
        result_d        = result_q;
        result_d[cnt_q] = alu_oput;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            result_q      <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        op_q          <= op;
                        opa_q         <= opa;
                        opb_q         <= opb;
                        result_q      <= '0;
                        cnt_q         <= '0;
                        state_q       <= S_RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    if (last_bit) begin
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_q       <= S_IDLE;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    start_ready_q <= 1'b1;
                    res_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    // Opcode pins come only from the latched op, so start_* never reaches the unit combinationally.
    assign alu_a       = op_q[1];
    assign alu_b       = op_q[0];
    assign alu_i0      = (state_q == S_RUN) & opa_q[cnt_q];
    assign alu_i1      = (state_q == S_RUN) & opb_q[cnt_q];
    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign dbg_state   = state_q;

`ifdef BSLS_SELFCHECK_EN
    logic [WIDTH-1:0] ref_word;

    always_comb begin
        ref_word = '0;
        case (op_q)
            2'b00:   ref_word = opa_q & opb_q;
            2'b01:   ref_word = opa_q | opb_q;
            2'b10:   ref_word = opa_q ^ opb_q;
            default: ref_word = ~opa_q;
        endcase
    end

    assign chk_err = (state_q == S_DONE) && (result_q != ref_word);
`endif

endmodule
